// File: rtl/awe_dsp_output_demux.sv
// awe_dsp_output_demux: steers the single DSP result stream to one of four
// channels through a 2-entry buffer. Mode changes wait until the buffer has drained.
// Optional feature macro: AWE_DSP_OUT_BCAST_EN (adds the bcast port; the head
// word is offered to all four channels and pops once every channel has taken it).
module awe_dsp_output_demux #(
  parameter int C_DATA_WIDTH = 18,
  parameter int C_CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic                    mode_update,
`ifdef AWE_DSP_OUT_BCAST_EN
  input  logic                    bcast,
`endif
  input  logic [C_DATA_WIDTH-1:0] datain,
  input  logic                    datain_valid,
  output logic                    datain_ready,
  output logic [C_DATA_WIDTH-1:0] dataout_0,
  output logic [C_DATA_WIDTH-1:0] dataout_1,
  output logic [C_DATA_WIDTH-1:0] dataout_2,
  output logic [C_DATA_WIDTH-1:0] dataout_3,
  output logic [3:0]              dataout_valid,
  input  logic [3:0]              dataout_ready,
  output logic [1:0]              active_mode,
  output logic                    busy,
  output logic [C_CNT_WIDTH-1:0]  word_cnt_0,
  output logic [C_CNT_WIDTH-1:0]  word_cnt_1,
  output logic [C_CNT_WIDTH-1:0]  word_cnt_2,
  output logic [C_CNT_WIDTH-1:0]  word_cnt_3
);

  typedef enum logic [1:0] {RUN, DRAIN, SWITCH} state_t;

  state_t                  state, state_nxt;
  logic [C_DATA_WIDTH-1:0] mem [2];
  logic                    rd_ptr, wr_ptr;
  logic [1:0]              count;
  logic [1:0]              pending_mode;
  logic [C_DATA_WIDTH-1:0] hold_q, dout;
  logic                    push, pop, nonempty;
  logic [3:0]              hs, valid_mask;
  logic                    bcast_act;
  logic [3:0]              done;
  logic [C_CNT_WIDTH-1:0]  cnt [4];

  assign nonempty     = (count != 2'd0);
  assign valid_mask   = bcast_act ? ~done : (4'b0001 << active_mode);
  assign dataout_valid = (nonempty && state != SWITCH) ? valid_mask : 4'b0000;
  assign hs           = dataout_valid & dataout_ready;
  // Broadcast pops only when every channel has taken the word, now or earlier.
  assign pop          = bcast_act ? ((done | hs) == 4'hF) : (|hs);
  assign datain_ready = !rst && (state == RUN) && (count != 2'd2 || pop);
  assign push         = datain_valid && datain_ready;
  assign busy         = nonempty || (state != RUN);

  // Outputs show the head word; when empty they keep the last word shown.
  assign dout      = nonempty ? mem[rd_ptr] : hold_q;
  assign dataout_0 = dout;
  assign dataout_1 = dout;
  assign dataout_2 = dout;
  assign dataout_3 = dout;

  // Buffer storage: data only, no reset needed since outputs mask it when empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= datain;
  end

  // Buffer pointers, occupancy and the held output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      hold_q <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (nonempty) hold_q <= mem[rd_ptr];
    end
  end

  // Next-state logic: a mode request drains the buffer, then takes one SWITCH cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mode_update) state_nxt = (!nonempty && !push) ? SWITCH : DRAIN;
      DRAIN:   if (!nonempty) state_nxt = SWITCH;
      SWITCH:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State register, pending request (last one wins) and applied mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      pending_mode <= 2'd0;
      active_mode  <= 2'd0;
    end else begin
      state <= state_nxt;
      if (mode_update) pending_mode <= mode;
      if (state == SWITCH) active_mode <= mode_update ? mode : pending_mode;
    end
  end

`ifdef AWE_DSP_OUT_BCAST_EN
  logic bcast_pend;
  // Broadcast request/apply and the per-channel done mask for the head word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcast_pend <= 1'b0;
      bcast_act  <= 1'b0;
      done       <= 4'b0000;
    end else begin
      if (mode_update) bcast_pend <= bcast;
      if (state == SWITCH) bcast_act <= mode_update ? bcast : bcast_pend;
      if (pop) done <= 4'b0000;
      else if (bcast_act) done <= done | hs;
    end
  end
`else
  assign bcast_act = 1'b0;
  assign done      = 4'b0000;
`endif

  // Per-channel delivered-word counters; wrap naturally at 2^C_CNT_WIDTH.
  for (genvar k = 0; k < 4; k++) begin : g_cnt
    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt[k] <= '0;
      else if (hs[k]) cnt[k] <= cnt[k] + 1'b1;
    end
  end

  assign word_cnt_0 = cnt[0];
  assign word_cnt_1 = cnt[1];
  assign word_cnt_2 = cnt[2];
  assign word_cnt_3 = cnt[3];

endmodule

// File: doc/awe_dsp_output_demux.md
Name: awe_dsp_output_demux

Overview:
Return-path partner of the AWE DSP input mux. Takes the single DSP result stream and steers each word to one of four destination channels, selected by a 2-bit mode. Provides valid/ready handshakes on both sides and a 2-entry buffer so the DSP is never stalled by a single-cycle destination back-pressure. Mode changes are applied only when the block is drained, so no word is ever delivered to the wrong channel.

Parameters:
C_DATA_WIDTH, 18, width of the data words on input and all outputs.
C_CNT_WIDTH, 16, width of the per-channel delivered-word counters.

Ports:
clk  input  1  clock; all logic is rising-edge.
rst  input  1  reset; asynchronous, active-high.
mode  input  2  requested destination: 00=ch0, 01=ch1, 10=ch2, 11=ch3.
mode_update  input  1  1-cycle pulse; requests that mode be sampled and applied.
datain  input  C_DATA_WIDTH  DSP result word.
datain_valid  input  1  datain is valid.
datain_ready  output  1  block accepts datain this cycle.
dataout_0..dataout_3  output  C_DATA_WIDTH each  channel data, all driven from the head-of-buffer word.
dataout_valid  output  4  per-channel valid; at most one bit set, except in broadcast.
dataout_ready  input  4  per-channel ready.
active_mode  output  2  mode currently applied.
busy  output  1  buffer non-empty or mode change pending.
word_cnt_0..word_cnt_3  output  C_CNT_WIDTH each  words delivered per channel.

Behaviour:
- Reset values: datain_ready=0 during rst, 1 on the first cycle after release; dataout_valid=0; dataout_x=0; active_mode=00; busy=0; word_cnt_x=0; buffer empty; FSM=RUN.
- Buffer: 2-entry FIFO. Push when datain_valid&&datain_ready. Pop when the head word is handed off (dataout_valid[active_mode]&&dataout_ready[active_mode]). Push and pop in the same cycle are allowed, including when full.
- Latency: a word pushed at cycle N with an empty buffer has its valid asserted at N+1. Back-to-back throughput is 1 word/cycle when the destination ready is held high.
- datain_ready = FSM==RUN && (count<2 || pop this cycle).
- dataout_valid[active_mode] = buffer non-empty && FSM!=SWITCH. All other valid bits are 0.
- FSM:
  - RUN: normal operation. On mode_update, latch pending_mode=mode. If the buffer is empty and there is no push this cycle, go to SWITCH; otherwise go to DRAIN.
  - DRAIN: datain_ready=0 while the buffer empties. When count==0, go to SWITCH.
  - SWITCH: one cycle. active_mode<=pending_mode, then return to RUN.
- mode_update while in DRAIN or SWITCH: pending_mode is overwritten; the last request wins.
- mode_update naming the current active_mode still passes through SWITCH (one idle cycle).
- busy = count!=0 || FSM!=RUN.
- word_cnt_k increments on each pop delivered to channel k and wraps modulo 2^C_CNT_WIDTH.
- dataout_x holds its value while valid is low (no X-propagation).
- Data is passed bit-exact; no arithmetic is applied.
- Asserting rst mid-operation flushes the buffer, discards the pending mode and clears the counters immediately.

Optional Feature:
Macro: AWE_DSP_OUT_BCAST_EN.
- Defined: adds input port bcast (1 bit), sampled together with mode on mode_update and applied in SWITCH.
- In broadcast, the head word drives dataout_valid=4'b1111. A 4-bit done mask records each channel's handshake, and valid[k] drops once channel k has taken the word.
- The word pops when the mask plus the current handshakes cover all four channels; the mask then clears.
- Every channel that takes the word increments its word_cnt_k.
- Not defined: no bcast port, and behaviour is exactly as above.

Test Plan:
- Reset then stream: mode=01 with mode_update, then words 0x00011,0x00022,0x00033 with dataout_ready=4'b0010 -> same values appear on dataout_1 one cycle after each push, valid only on bit 1, and word_cnt_1=3.
- Back-pressure: ready[0]=0 for 4 cycles during a stream to ch0 -> buffer fills to 2, datain_ready=0, no word is lost or duplicated after ready returns.
- Mode change with data in flight: 2 words buffered for ch2, mode_update to ch3 -> datain_ready=0 until both words leave on ch2, one SWITCH cycle follows, the next word goes to ch3, and active_mode=11.
- Two mode_update pulses during DRAIN (01 then 11) -> active_mode=11 after the switch.
- Counter wrap with C_CNT_WIDTH=4: 17 words to ch0 -> word_cnt_0=1.
- Broadcast (AWE_DSP_OUT_BCAST_EN defined): word 0x2AAAA with the ready bits arriving on different cycles (ch3, ch0, ch1+ch2) -> each channel takes the word exactly once, the pop happens on the third handshake cycle, and all counters equal 1.
